// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types, constants and helpers for the 4-way round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef logic [N_REQ-1:0] req_t;
  typedef logic [SEL_W-1:0] idx_t;

  // Arbiter FSM states.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Per-edge datapath action chosen by the FSM.
  // The output process turns this into register updates.
  typedef enum logic [2:0] {
    ACT_NONE     = 3'd0,  // hold every register
    ACT_TAKE     = 3'd1,  // new owner (first grant or handoff)
    ACT_HOLD_INC = 3'd2,  // owner keeps the mux, count one more cycle
    ACT_HOLD_CLR = 3'd3,  // lone owner at the limit keeps the mux, restart count
    ACT_RELEASE  = 3'd4   // nobody wants the mux, drop the grant
  } act_e;

  // Binary index -> one-hot request/grant vector.
  function automatic req_t onehot(input idx_t idx);
    req_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // One-hot vector -> binary index. Zero-hot input yields index 0.
  function automatic idx_t index_of(input req_t oh);
    idx_t idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: scans req starting at ptr and wrapping
// modulo 4; the first set bit wins. valid_o is low when req is all-zero.
module mux4_rr_arbiter_rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  req_t req_i,
  input  idx_t ptr_i,
  output idx_t idx_o,
  output logic valid_o
);

  // Walk the search order from the farthest to the nearest offset.
  // The nearest set request is assigned last and therefore wins.
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // so no path leaves a value unassigned and no latch is inferred.
    idx_o   = ptr_i;
    valid_o = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[idx_t'(ptr_i + idx_t'(i))]) begin
        idx_o   = idx_t'(ptr_i + idx_t'(i));
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 4:1 mux.
// It grants one requester at a time and caps ownership at MAX_HOLD cycles
// while others wait. Priority rotates past each new owner.
// All outputs are registered. There is no combinational path from req.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4,  // legal 1..16
  parameter int HOLD_W   = 4   // 2**HOLD_W >= MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  // Last hold_cnt value before the owner must yield to a waiting requester.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  req_t              grant_q, grant_d;
  idx_t              sel_q,   sel_d;
  logic              busy_q,  busy_d;
  idx_t              ptr_q,   ptr_d;
  logic [HOLD_W-1:0] hold_q,  hold_d;
  act_e              act;

  req_t masked_req;
  idx_t pick_idx;
  logic pick_valid;
  logic own_req;
  logic at_limit;

  // In GRANT, sel_q is the current owner. It is removed from the search so
  // the picker sees only the other requesters. In IDLE every request counts.
  assign masked_req = (state_q == GRANT) ? (req & ~onehot(sel_q)) : req;
  assign own_req    = req[sel_q];
  assign at_limit   = (hold_q == HOLD_LAST);

  // One picker serves both the first grant from IDLE and every handoff.
  mux4_rr_arbiter_rr_pick4 u_pick (
    .req_i   (masked_req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // State register plus the registered outputs, ptr and hold counter.
  // All of them clear immediately when rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic: pick the next state and the datapath action for this edge.
  always_comb begin
    state_d = state_q;
    act     = ACT_NONE;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          act     = ACT_TAKE;
        end
      end
      GRANT: begin
        if (!own_req) begin
          // The owner has let go. Hand off with no gap, or go idle.
          if (pick_valid) begin
            act = ACT_TAKE;
          end else begin
            state_d = IDLE;
            act     = ACT_RELEASE;
          end
        end else if (!at_limit) begin
          act = ACT_HOLD_INC;
        end else if (pick_valid) begin
          // Hold limit reached with others waiting: preempt.
          act = ACT_TAKE;
        end else begin
          // Hold limit reached but nobody else wants the mux: keep it.
          act = ACT_HOLD_CLR;
        end
      end
      default: begin
        state_d = IDLE;
        act     = ACT_RELEASE;
      end
    endcase
  end

  // Output logic: turn the chosen action into next values of the registered outputs, ptr and hold counter.
  always_comb begin
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (act)
      ACT_TAKE: begin
        grant_d = onehot(pick_idx);
        sel_d   = pick_idx;
        busy_d  = 1'b1;
        hold_d  = '0;
        ptr_d   = idx_t'(pick_idx + idx_t'(1));  // 2-bit wrap: 3 -> 0
      end
      ACT_HOLD_INC: begin
        hold_d = hold_q + HOLD_W'(1);
      end
      ACT_HOLD_CLR: begin
        hold_d = '0;
      end
      ACT_RELEASE: begin
        // sel keeps its value so the mux output stays defined while idle.
        grant_d = '0;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
      default: begin
        busy_d = (state_q == GRANT);
      end
    endcase
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = busy_q;

endmodule
